// File: rtl/sound_event_sequencer.sv
// Sound-event sequencer: captures event edges, arbitrates by fixed priority with pre-emption,
// and plays each event as one or two timed notes for the tone generator.
`timescale 1ns/1ps
module sound_event_sequencer #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned PS_W    = 10,
  parameter int unsigned DUR_W   = 8,
  parameter int unsigned CLK_HZ  = 31_500_000,
  parameter int unsigned TICK_HZ = 1000,
  localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic [N_CH-1:0]       event_in,
  input  logic [N_CH*PS_W-1:0]  ch_tone_a,
  input  logic [N_CH*PS_W-1:0]  ch_tone_b,
  input  logic [N_CH*DUR_W-1:0] ch_dur,
  input  logic [N_CH-1:0]       ch_two_note,
  input  logic                  mute,
  output logic [PS_W-1:0]       preScaleValue,
  output logic                  enabler,
  output logic                  busy,
  output logic [CH_W-1:0]       active_ch,
  output logic                  note_done
);

  localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StPlayA, StPlayB} state_e;

  state_e            state_q, state_d;
  logic [N_CH-1:0]   prev_q, pending_q, pending_d, clr;
  logic [DUR_W-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PS_W-1:0]   ps_q, ps_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              en_q, en_d;
  logic              done_q, done_d;

  logic              pend_any, start, tick;
  logic [CH_W-1:0]   pend_idx;
  logic [DUR_W-1:0]  dur_new, dur_cur;

  // Lowest-index pending channel wins arbitration.
  always_comb begin
    pend_any = |pending_q;
    pend_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pending_q[i]) pend_idx = CH_W'(i);
    end
  end

  assign start   = pend_any && ((state_q == StIdle) || (pend_idx < ch_q));
  assign tick    = (cnt_q == CntMax);
  assign dur_new = ch_dur[pend_idx*DUR_W +: DUR_W];
  assign dur_cur = ch_dur[ch_q*DUR_W +: DUR_W];

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    ps_d    = ps_q;
    ch_d    = ch_q;
    done_d  = 1'b0;
    clr     = '0;
    if (start) begin
      clr[pend_idx] = 1'b1;
      ch_d    = pend_idx;
      ps_d    = ch_tone_a[pend_idx*PS_W +: PS_W];
      timer_d = (dur_new == '0) ? DUR_W'(1) : dur_new;
      cnt_d   = '0;
      state_d = StPlayA;
    end else begin
      unique case (state_q)
        StIdle: ;
        StPlayA, StPlayB: begin
          cnt_d = tick ? '0 : cnt_q + 1'b1;
          if (tick) begin
            if (timer_q == DUR_W'(1)) begin
              if (state_q == StPlayA && ch_two_note[ch_q]) begin
                ps_d    = ch_tone_b[ch_q*PS_W +: PS_W];
                timer_d = (dur_cur == '0) ? DUR_W'(1) : dur_cur;
                state_d = StPlayB;
              end else begin
                state_d = StIdle;
                done_d  = 1'b1;
              end
            end else begin
              timer_d = timer_q - 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
    // A fresh edge on a channel being cleared still wins, so it replays once more.
    pending_d = (pending_q & ~clr) | (event_in & ~prev_q);
    en_d      = (state_d != StIdle) && !mute;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= StIdle;
      prev_q    <= '0;
      pending_q <= '0;
      timer_q   <= '0;
      cnt_q     <= '0;
      ps_q      <= '0;
      ch_q      <= '0;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= event_in;
      pending_q <= pending_d;
      timer_q   <= timer_d;
      cnt_q     <= cnt_d;
      ps_q      <= ps_d;
      ch_q      <= ch_d;
      en_q      <= en_d;
      done_q    <= done_d;
    end
  end

  assign preScaleValue = ps_q;
  assign enabler       = en_q;
  assign busy          = (state_q != StIdle);
  assign active_ch     = ch_q;
  assign note_done     = done_q;

endmodule
